ws2812_bit_encoder: RTL and testbench

//   Downstream output stage of serial_matrix_driver: accepts 24-bit GRB pixel words over a

---
 rtl/ws2812_bit_encoder.sv | 160 ++++++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_encoder.sv
// ---------------------------------------------------------------------------
// ws2812_bit_encoder
//
// Output stage of the matrix driver. Accepts GRB pixel words over a valid/ready
// handshake and shifts them out MSB-first onto the single-wire WS2812 DIN line.
// Each bit is a fixed-length period. A '1' holds DIN high for T1H_CYC cycles and
// a '0' holds it high for T0H_CYC cycles. After the last pixel of a frame, DIN
// is held low for LATCH_CYC cycles so the LED chain latches the new colours.
//
// Ports
//   CLK        in   1      system clock, rising edge
//   RESET      in   1      synchronous reset, active high
//   pix_data   in   PIX_W  pixel word (G,R,B), MSB transmitted first
//   pix_last   in   1      pixel is the last of its frame (latch gap follows)
//   pix_valid  in   1      upstream offers a pixel
//   pix_ready  out  1      encoder accepts a pixel this cycle
//   DIN        out  1      registered serial line to the LED chain
//   busy       out  1      encoder is not idle
//   underrun   out  1      one-cycle pulse when a stream starves mid-frame
// ---------------------------------------------------------------------------
module ws2812_bit_encoder #(
   parameter int PIX_W     = 24,
   parameter int T0H_CYC   = 8,
   parameter int T1H_CYC   = 16,
   parameter int BIT_CYC   = 25,
   parameter int LATCH_CYC = 1000
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [PIX_W-1:0] pix_data,
   input  logic             pix_last,
   input  logic             pix_valid,
   output logic             pix_ready,
   output logic             DIN,
   output logic             busy,
   output logic             underrun
);

   localparam int CW = (BIT_CYC > 1)   ? $clog2(BIT_CYC)     : 1;
   localparam int BW = (PIX_W > 1)     ? $clog2(PIX_W)       : 1;
   localparam int LW = (LATCH_CYC > 0) ? $clog2(LATCH_CYC+1) : 1;

   localparam logic [CW-1:0] CYC_LAST   = CW'(BIT_CYC - 1);
   localparam logic [CW-1:0] T0H_C      = CW'(T0H_CYC);
   localparam logic [CW-1:0] T1H_C      = CW'(T1H_CYC);
   localparam logic [BW-1:0] BIT_TOP    = BW'(PIX_W - 1);
   localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CYC - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SEND  = 2'd1,
      LATCH = 2'd2
   } state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cyc, cyc_nxt;
   logic [BW-1:0]    bit_idx, bit_idx_nxt;
   logic [PIX_W-1:0] shreg, shreg_nxt;
   logic             last_flag, last_flag_nxt;
   logic [LW-1:0]    latch_cnt, latch_cnt_nxt;
   logic             din_nxt;
   logic             underrun_nxt;
   logic             boundary;
   logic             take;
   logic [CW-1:0]    thigh_nxt;

   // Next-state logic. The pixel boundary is the final cycle of bit 0. A
   // non-last pixel can hand over to a new pixel at that point without any
   // gap. DIN is registered, so it is computed from the values the counters
   // take at this edge. The line therefore stays aligned with cyc, and DIN
   // rises in the first cycle after a transfer.
   always_comb begin
      state_nxt     = state;
      cyc_nxt       = cyc;
      bit_idx_nxt   = bit_idx;
      shreg_nxt     = shreg;
      last_flag_nxt = last_flag;
      latch_cnt_nxt = latch_cnt;
      underrun_nxt  = 1'b0;

      boundary  = (state == SEND) && (cyc == CYC_LAST) && (bit_idx == '0);
      pix_ready = !RESET && ((state == IDLE) || (boundary && !last_flag));
      take      = pix_valid && pix_ready;

      case (state)
         IDLE: begin
            if (take) begin
               state_nxt     = SEND;
               cyc_nxt       = '0;
               bit_idx_nxt   = BIT_TOP;
               shreg_nxt     = pix_data;
               last_flag_nxt = pix_last;
            end
         end
         SEND: begin
            if (cyc != CYC_LAST) begin
               cyc_nxt = cyc + 1'b1;
            end else if (bit_idx != '0) begin
               cyc_nxt     = '0;
               bit_idx_nxt = bit_idx - 1'b1;
               shreg_nxt   = shreg << 1;
            end else if (last_flag) begin
               state_nxt     = LATCH;
               cyc_nxt       = '0;
               latch_cnt_nxt = '0;
            end else if (take) begin
               cyc_nxt       = '0;
               bit_idx_nxt   = BIT_TOP;
               shreg_nxt     = pix_data;
               last_flag_nxt = pix_last;
            end else begin
               state_nxt    = IDLE;
               cyc_nxt      = '0;
               underrun_nxt = 1'b1;
            end
         end
         LATCH: begin
            if (latch_cnt == LATCH_LAST) begin
               state_nxt     = IDLE;
               latch_cnt_nxt = '0;
            end else begin
               latch_cnt_nxt = latch_cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      thigh_nxt = shreg_nxt[PIX_W-1] ? T1H_C : T0H_C;
      din_nxt   = (state_nxt == SEND) && (cyc_nxt < thigh_nxt);
   end

   // State and datapath registers. Reset discards any partial pixel without
   // starting a latch gap.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state     <= IDLE;
         cyc       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         last_flag <= 1'b0;
         latch_cnt <= '0;
         DIN       <= 1'b0;
         underrun  <= 1'b0;
      end else begin
         state     <= state_nxt;
         cyc       <= cyc_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         last_flag <= last_flag_nxt;
         latch_cnt <= latch_cnt_nxt;
         DIN       <= din_nxt;
         underrun  <= underrun_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// ---------------------------------------------------------------------------
// tb_ws2812_bit_encoder
//
// Directed bench for ws2812_bit_encoder. Instance dutA uses the default timing.
// Instance dutB uses a short timing set (T0H=2, T1H=4, BIT=6, LATCH=1).
// The DIN waveform of each bit is captured into a vector, where position k is
// cycle k of the bit. That vector is compared with a wave built from the
// pulse widths.
// ---------------------------------------------------------------------------
module tb_ws2812_bit_encoder;

   logic        CLK = 1'b0;
   logic        RESET;

   logic [23:0] a_data;
   logic        a_last, a_valid;
   logic        a_ready, a_din, a_busy, a_underrun;

   logic [23:0] b_data;
   logic        b_last, b_valid;
   logic        b_ready, b_din, b_busy, b_underrun;

   int nChecks = 0;
   int nErrors = 0;

   // 10 ns clock
   always #5 CLK = ~CLK;

   ws2812_bit_encoder dutA (
      .CLK       (CLK),
      .RESET     (RESET),
      .pix_data  (a_data),
      .pix_last  (a_last),
      .pix_valid (a_valid),
      .pix_ready (a_ready),
      .DIN       (a_din),
      .busy      (a_busy),
      .underrun  (a_underrun)
   );

   ws2812_bit_encoder #(
      .PIX_W     (24),
      .T0H_CYC   (2),
      .T1H_CYC   (4),
      .BIT_CYC   (6),
      .LATCH_CYC (1)
   ) dutB (
      .CLK       (CLK),
      .RESET     (RESET),
      .pix_data  (b_data),
      .pix_last  (b_last),
      .pix_valid (b_valid),
      .pix_ready (b_ready),
      .DIN       (b_din),
      .busy      (b_busy),
      .underrun  (b_underrun)
   );

   // Watchdog so the run always ends on its own
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Advance one clock and sample just after the edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Single comparison point
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nChecks++;
      assert (obs === exp) else begin
         nErrors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive the upstream side of one instance
   task automatic applyStimulus(input int sel, input logic [23:0] data, input logic last, input logic valid);
      if (sel == 0) begin
         a_data = data; a_last = last; a_valid = valid;
      end else begin
         b_data = data; b_last = last; b_valid = valid;
      end
   endtask

   // Expected DIN wave of a single bit: high for th cycles, then low
   function automatic logic [31:0] bitWave(input int th);
      logic [31:0] w;
      w = '0;
      for (int k = 0; k < th; k++) w[k] = 1'b1;
      return w;
   endfunction

   // Called in the first cycle after a transfer. Captures every bit and stops
   // in the boundary cycle (the last cycle of bit 0), without the final tick.
   task automatic checkPixel(input int sel, input logic [23:0] pix, input string tag);
      int          bc, t0, t1;
      logic [31:0] obs;
      bc = (sel == 0) ? 25 : 6;
      t0 = (sel == 0) ? 8  : 2;
      t1 = (sel == 0) ? 16 : 4;
      for (int i = 23; i >= 0; i--) begin
         obs = '0;
         for (int k = 0; k < bc; k++) begin
            obs[k] = (sel == 0) ? a_din : b_din;
            if (!(i == 0 && k == bc - 1)) tick();
         end
         checkOutput($sformatf("%s bit%0d", tag, i), obs, bitWave(pix[i] ? t1 : t0));
      end
   endtask

   // Called in the first latch cycle; returns in the cycle after the gap
   task automatic checkLatch(input int sel, input int n, input string tag);
      int hiCnt, idleCnt, rdyCnt;
      hiCnt = 0; idleCnt = 0; rdyCnt = 0;
      for (int j = 0; j < n; j++) begin
         if ((sel == 0) ? a_din   : b_din)    hiCnt++;
         if (!((sel == 0) ? a_busy : b_busy)) idleCnt++;
         if ((sel == 0) ? a_ready : b_ready)  rdyCnt++;
         tick();
      end
      checkOutput({tag, " latch din high cycles"}, hiCnt, 0);
      checkOutput({tag, " latch idle cycles"}, idleCnt, 0);
      checkOutput({tag, " latch ready cycles"}, rdyCnt, 0);
      checkOutput({tag, " idle after latch"}, (sel == 0) ? a_busy : b_busy, 0);
   endtask

   // Directed sequence
   initial begin
      int lowCnt;
      RESET = 1'b1;
      applyStimulus(0, 24'h0, 1'b0, 1'b0);
      applyStimulus(1, 24'h0, 1'b0, 1'b0);
      tick(); tick();

      // Reset state
      checkOutput("reset ready", a_ready, 0);
      checkOutput("reset din", a_din, 0);
      checkOutput("reset busy", a_busy, 0);
      checkOutput("reset underrun", a_underrun, 0);
      checkOutput("reset ready B", b_ready, 0);
      RESET = 1'b0;
      #1;
      checkOutput("idle ready", a_ready, 1);

      // Test 1: single last pixel, followed by the latch gap
      applyStimulus(0, 24'h800001, 1'b1, 1'b1);
      tick();
      a_valid = 1'b0;
      checkPixel(0, 24'h800001, "t1");
      checkOutput("t1 boundary ready", a_ready, 0);
      checkOutput("t1 boundary busy", a_busy, 1);
      tick();
      checkLatch(0, 1000, "t1");

      // Test 2: seamless two-pixel stream with valid held
      applyStimulus(0, 24'hFFFFFF, 1'b0, 1'b1);
      tick();
      applyStimulus(0, 24'h000000, 1'b1, 1'b1);
      checkPixel(0, 24'hFFFFFF, "t2a");
      checkOutput("t2 boundary ready", a_ready, 1);
      tick();
      a_valid = 1'b0;
      checkPixel(0, 24'h000000, "t2b");
      checkOutput("t2b boundary ready", a_ready, 0);
      tick();
      checkLatch(0, 1000, "t2");

      // Test 3: starved stream raises underrun once
      applyStimulus(0, 24'h0F0F0F, 1'b0, 1'b1);
      tick();
      a_valid = 1'b0;
      checkPixel(0, 24'h0F0F0F, "t3");
      checkOutput("t3 boundary ready", a_ready, 1);
      checkOutput("t3 boundary underrun", a_underrun, 0);
      tick();
      checkOutput("t3 underrun pulse", a_underrun, 1);
      checkOutput("t3 idle busy", a_busy, 0);
      checkOutput("t3 idle din", a_din, 0);
      tick();
      checkOutput("t3 underrun cleared", a_underrun, 0);
      lowCnt = 0;
      for (int j = 0; j < 5; j++) begin
         if (!a_din && !a_busy) lowCnt++;
         tick();
      end
      checkOutput("t3 idle quiet cycles", lowCnt, 5);

      // Test 4: reset in the middle of a pixel, then a clean resend
      applyStimulus(0, 24'hFFFFFF, 1'b1, 1'b1);
      tick();
      a_valid = 1'b0;
      for (int j = 0; j < 300; j++) tick();
      checkOutput("t4 din before reset", a_din, 1);
      RESET = 1'b1;
      tick();
      checkOutput("t4 reset din", a_din, 0);
      checkOutput("t4 reset busy", a_busy, 0);
      checkOutput("t4 reset ready", a_ready, 0);
      RESET = 1'b0;
      tick();
      checkOutput("t4 idle after reset", a_busy, 0);
      applyStimulus(0, 24'h5A0C81, 1'b1, 1'b1);
      tick();
      a_valid = 1'b0;
      checkPixel(0, 24'h5A0C81, "t4");
      tick();
      checkLatch(0, 1000, "t4");

      // Test 5: valid held through the latch gap is ignored until IDLE
      applyStimulus(0, 24'h000001, 1'b1, 1'b1);
      tick();
      applyStimulus(0, 24'h123456, 1'b1, 1'b1);
      checkPixel(0, 24'h000001, "t5a");
      tick();
      checkLatch(0, 1000, "t5");
      checkOutput("t5 idle ready", a_ready, 1);
      checkOutput("t5 idle din", a_din, 0);
      tick();
      a_valid = 1'b0;
      checkPixel(0, 24'h123456, "t5b");
      RESET = 1'b1;
      tick();
      RESET = 1'b0;
      tick();

      // Test 6: short timing set on dutB
      applyStimulus(1, 24'hAAAAAA, 1'b1, 1'b1);
      tick();
      b_valid = 1'b0;
      checkPixel(1, 24'hAAAAAA, "t6");
      checkOutput("t6 boundary ready", b_ready, 0);
      tick();
      checkOutput("t6 latch din", b_din, 0);
      checkOutput("t6 latch busy", b_busy, 1);
      tick();
      checkOutput("t6 idle after one latch cycle", b_busy, 0);
      checkOutput("t6 idle ready", b_ready, 1);

      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule
